// File: rtl/rf_writeback_ctrl_pkg.sv
// Shared types and default sizes for the register-file write-back controller.
package rf_writeback_ctrl_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_REG_NUM_BIT = 5;
  localparam int REG_ZERO        = 0;

  typedef enum logic {
    GNT_EXU = 1'b0,
    GNT_LSU = 1'b1
  } grant_e;

endpackage

// File: rtl/rf_writeback_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; req/gnt bit 0 is EXU, bit 1 is LSU.
// Grant is combinational, and it is forced to zero while reset is asserted.
module rr_arb2
  import rf_writeback_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  grant_e r_last_grant;

  always_comb begin
    o_gnt = 2'b00;
    if (i_rst_n) begin
      if (&i_req) begin
        o_gnt = (r_last_grant == GNT_EXU) ? 2'b10 : 2'b01;
      end else begin
        o_gnt = i_req;
      end
    end
  end

  // Every grant is also a fire, because ready is the grant itself.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_last_grant <= GNT_EXU;
    end else if (o_gnt[1]) begin
      r_last_grant <= GNT_LSU;
    end else if (o_gnt[0]) begin
      r_last_grant <= GNT_EXU;
    end
  end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Arbitrates EXU/LSU results onto the register-file write port.
// Also tracks which registers are busy, for the issue stage's RAW/WAW stalls.
module rf_writeback_ctrl
  import rf_writeback_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int REG_NUM_BIT = DEF_REG_NUM_BIT
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_alloc_valid,
  input  logic [REG_NUM_BIT-1:0] i_alloc_rd,
  output logic                   o_alloc_ready,
  input  logic [REG_NUM_BIT-1:0] i_rs1,
  input  logic [REG_NUM_BIT-1:0] i_rs2,
  output logic                   o_rs1_busy,
  output logic                   o_rs2_busy,
  input  logic                   i_exu_valid,
  input  logic [REG_NUM_BIT-1:0] i_exu_rd,
  input  logic [DATA_WIDTH-1:0]  i_exu_data,
  output logic                   o_exu_ready,
  input  logic                   i_lsu_valid,
  input  logic [REG_NUM_BIT-1:0] i_lsu_rd,
  input  logic [DATA_WIDTH-1:0]  i_lsu_data,
  output logic                   o_lsu_ready,
  output logic                   o_rf_wen,
  output logic [REG_NUM_BIT-1:0] o_rf_waddr,
  output logic [DATA_WIDTH-1:0]  o_rf_wdata,
  output logic [REG_NUM_BIT:0]   o_pending_cnt
);

  localparam int NREG = 1 << REG_NUM_BIT;
  localparam logic [REG_NUM_BIT-1:0] RZ = REG_NUM_BIT'(REG_ZERO);

  logic [NREG-1:0]        r_busy;
  logic [REG_NUM_BIT:0]   r_pending;
  logic                   r_wen;
  logic [REG_NUM_BIT-1:0] r_waddr;
  logic [DATA_WIDTH-1:0]  r_wdata;

  logic [1:0]             w_gnt;
  logic                   w_res_fire;
  logic [REG_NUM_BIT-1:0] w_res_rd;
  logic [DATA_WIDTH-1:0]  w_res_data;
  logic                   w_alloc_fire;
  logic                   w_set;
  logic                   w_clr;
  logic [NREG-1:0]        w_set_mask;
  logic [NREG-1:0]        w_clr_mask;
  logic [NREG-1:0]        w_busy_nxt;
  logic                   w_inc;
  logic                   w_dec;

  rr_arb2 u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   ({i_lsu_valid, i_exu_valid}),
    .o_gnt   (w_gnt)
  );

  assign o_exu_ready = w_gnt[0];
  assign o_lsu_ready = w_gnt[1];

  assign w_res_fire = |w_gnt;
  assign w_res_rd   = w_gnt[1] ? i_lsu_rd   : i_exu_rd;
  assign w_res_data = w_gnt[1] ? i_lsu_data : i_exu_data;

  assign o_alloc_ready = (i_alloc_rd == RZ) || !r_busy[i_alloc_rd];
  assign w_alloc_fire  = i_alloc_valid && o_alloc_ready;

  // Source queries see registered state only; a same-cycle retire still reads busy.
  assign o_rs1_busy = (i_rs1 != RZ) && r_busy[i_rs1];
  assign o_rs2_busy = (i_rs2 != RZ) && r_busy[i_rs2];

  assign w_set      = w_alloc_fire && (i_alloc_rd != RZ);
  assign w_clr      = w_res_fire && (w_res_rd != RZ);
  assign w_set_mask = w_set ? (NREG'(1) << i_alloc_rd) : '0;
  assign w_clr_mask = w_clr ? (NREG'(1) << w_res_rd) : '0;

  // Set is applied after clear so a new owner outranks a retiring one.
  assign w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;

  assign w_inc = w_set && !r_busy[i_alloc_rd];
  assign w_dec = w_clr && r_busy[w_res_rd] && !(w_set && (i_alloc_rd == w_res_rd));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_busy    <= '0;
      r_pending <= '0;
      r_wen     <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_pending <= r_pending + (REG_NUM_BIT+1)'(w_inc) - (REG_NUM_BIT+1)'(w_dec);
      r_wen     <= w_clr;
      if (w_res_fire) begin
        r_waddr <= w_res_rd;
        r_wdata <= w_res_data;
      end
    end
  end

  assign o_rf_wen      = r_wen;
  assign o_rf_waddr    = r_waddr;
  assign o_rf_wdata    = r_wdata;
  assign o_pending_cnt = r_pending;

endmodule
